alu_rr_arbiter: RTL and testbench

- Shares one combinational 4-bit ALU (A, B, 3-bit sel -> result, carry, zero) between NUM_REQ independent requesters.
- Round-robin arbitration with a valid/ready handshake on each request port.
- Drives the ALU operand/opcode inputs from the winner and captures the ALU outputs into a single registered response slot, tagged with the requester id.
- Sits between the requesting engines and the shared ALU instance; the ALU itself is external.

---
 rtl/alu_rr_arbiter.sv | 109 ++++++++++
 tb/tb_alu_rr_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin sharing of one external 4-bit ALU with a registered, id-tagged response slot.
// Define ALU_RR_ARBITER_STATS_EN to add saturating per-requester grant counters on grant_cnt.
module alu_rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDW = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [4*NUM_REQ-1:0] req_a,
    input  logic [4*NUM_REQ-1:0] req_b,
    input  logic [3*NUM_REQ-1:0] req_sel,
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    output logic [2:0]           alu_sel,
    input  logic [3:0]           alu_result,
    input  logic                 alu_carry,
    input  logic                 alu_zero,
`ifdef ALU_RR_ARBITER_STATS_EN
    output logic [8*NUM_REQ-1:0] grant_cnt,
`endif
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [3:0]           rsp_result,
    output logic                 rsp_carry,
    output logic                 rsp_zero
);
    logic [IDW-1:0] ptr_q, ptr_d, win, idx, rsp_id_q, rsp_id_d;
    logic [IDW:0]   sum;
    logic [3:0]     rsp_result_q, rsp_result_d;
    logic           rsp_valid_q, rsp_valid_d, rsp_carry_q, rsp_carry_d, rsp_zero_q, rsp_zero_d;
    logic           found, can_accept, grant;

    // Scan from the highest offset down so the offset closest to the pointer wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_q} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NUM_REQ)) sum = sum - (IDW+1)'(NUM_REQ);
            idx = sum[IDW-1:0];
            if (req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign can_accept = !rsp_valid_q || rsp_ready;
    assign grant      = found && can_accept;
    assign req_ready  = grant ? NUM_REQ'(1) << win : '0;
    assign alu_a      = grant ? req_a[4*win +: 4] : '0;
    assign alu_b      = grant ? req_b[4*win +: 4] : '0;
    assign alu_sel    = grant ? req_sel[3*win +: 3] : '0;

    always_comb begin
        rsp_valid_d  = grant || (rsp_valid_q && !rsp_ready);
        rsp_id_d     = grant ? win : rsp_id_q;
        rsp_result_d = grant ? alu_result : rsp_result_q;
        rsp_carry_d  = grant ? alu_carry : rsp_carry_q;
        rsp_zero_d   = grant ? alu_zero : rsp_zero_q;
        ptr_d        = !grant ? ptr_q : (win == IDW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
            ptr_q        <= '0;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_zero_q   <= rsp_zero_d;
            ptr_q        <= ptr_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_zero   = rsp_zero_q;

`ifdef ALU_RR_ARBITER_STATS_EN
    logic [NUM_REQ-1:0][7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant && win == IDW'(i) && cnt_q[i] != 8'hff) cnt_d[i] = cnt_q[i] + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign grant_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: directed and randomized checks of alu_rr_arbiter against a queue-free reference model.
module tb_alu_rr_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0, req_ready;
    logic [4*N-1:0] req_a = '0, req_b = '0;
    logic [3*N-1:0] req_sel = '0;
    logic [3:0]     alu_a, alu_b, alu_result, rsp_result;
    logic [2:0]     alu_sel;
    logic           alu_carry, alu_zero, rsp_valid, rsp_carry, rsp_zero;
    logic           rsp_ready = 1'b0;
    logic [1:0]     rsp_id;
`ifdef ALU_RR_ARBITER_STATS_EN
    logic [8*N-1:0] grant_cnt;
    int             mcnt[N];
`endif
    int             total = 0, bad = 0;
    int             ptr, mid, last_win;
    logic           mv, mc, mz;
    logic [3:0]     mres;

    always #5 clk = ~clk;

    alu_rr_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
`ifdef ALU_RR_ARBITER_STATS_EN
        .grant_cnt(grant_cnt),
`endif
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero)
    );

    // Stand-in for the external ALU: returns {zero, carry, result}.
    function automatic logic [5:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
        logic [4:0] r;
        r = s == 3'd0 ? {1'b0, a} + {1'b0, b} :
            s == 3'd1 ? {1'b0, a} - {1'b0, b} :
            s == 3'd2 ? {1'b0, a & b} :
            s == 3'd3 ? {1'b0, a | b} :
            s == 3'd4 ? {1'b0, a ^ b} : {1'b0, a};
        return {r[3:0] == 4'd0, r};
    endfunction

    assign {alu_zero, alu_carry, alu_result} = alu_f(alu_a, alu_b, alu_sel);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_grant();
        if (mv && !rsp_ready) return -1;
        for (int k = 0; k < N; k++)
            if (req_valid[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        ptr = 0; mv = 0; mid = 0; mres = 0; mc = 0; mz = 0;
`ifdef ALU_RR_ARBITER_STATS_EN
        foreach (mcnt[i]) mcnt[i] = 0;
`endif
    endtask

    // Check all outputs in the low phase, then advance the model across the rising edge.
    task automatic cycle();
        int g;
        #1;
        g = exp_grant();
        chk("req_ready", 32'(req_ready), g < 0 ? 0 : 1 << g);
        chk("alu_a", 32'(alu_a), g < 0 ? 0 : 32'(req_a[4*g +: 4]));
        chk("alu_b", 32'(alu_b), g < 0 ? 0 : 32'(req_b[4*g +: 4]));
        chk("alu_sel", 32'(alu_sel), g < 0 ? 0 : 32'(req_sel[3*g +: 3]));
        chk("rsp_valid", 32'(rsp_valid), 32'(mv));
        chk("rsp_id", 32'(rsp_id), mid);
        chk("rsp_result", 32'(rsp_result), 32'(mres));
        chk("rsp_carry", 32'(rsp_carry), 32'(mc));
        chk("rsp_zero", 32'(rsp_zero), 32'(mz));
`ifdef ALU_RR_ARBITER_STATS_EN
        for (int i = 0; i < N; i++) chk("grant_cnt", 32'(grant_cnt[8*i +: 8]), mcnt[i]);
`endif
        @(posedge clk);
        if (g >= 0) begin
            {mz, mc, mres} = alu_f(req_a[4*g +: 4], req_b[4*g +: 4], req_sel[3*g +: 3]);
            mid = g;
            mv  = 1;
            ptr = (g + 1) % N;
`ifdef ALU_RR_ARBITER_STATS_EN
            if (mcnt[g] < 255) mcnt[g]++;
`endif
        end else if (rsp_ready) mv = 0;
        last_win = g;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
        req_a[4*i +: 4]   = a;
        req_b[4*i +: 4]   = b;
        req_sel[3*i +: 3] = s;
        req_valid[i]      = 1'b1;
    endtask

    initial begin
        do_reset();
        #1;
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_id", 32'(rsp_id), 0);
        chk("rst_ready", 32'(req_ready), 0);
        // Single op: 9 + 8 wraps to 1 with carry.
        rsp_ready = 1'b1;
        set_req(0, 4'd9, 4'd8, 3'd0);
        #1 chk("single_grant", 32'(req_ready), 32'b0001);
        cycle();
        req_valid = '0;
        #1;
        chk("single_valid", 32'(rsp_valid), 1);
        chk("single_id", 32'(rsp_id), 0);
        chk("single_result", 32'(rsp_result), 1);
        chk("single_carry", 32'(rsp_carry), 1);
        chk("single_zero", 32'(rsp_zero), 0);
        // Backpressure holds the slot and suppresses grants.
        rsp_ready = 1'b0;
        set_req(1, 4'd3, 4'd2, 3'd1);
        set_req(2, 4'd7, 4'd7, 3'd4);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", 32'(req_ready), 0);
            chk("bp_hold", 32'(rsp_result), 1);
            cycle();
        end
        rsp_ready = 1'b1;
        #1 chk("bp_grant", 32'(req_ready), 32'b0010);
        cycle();
        req_valid[1] = 1'b0;
        #1;
        chk("bp_id", 32'(rsp_id), 1);
        chk("bp_result", 32'(rsp_result), 1);
        chk("bp_carry", 32'(rsp_carry), 0);
        cycle();
        req_valid = '0;
        // Zero flag from requester 3, then pointer wraps to 0.
        set_req(3, 4'h5, 4'h5, 3'd4);
        cycle();
        req_valid = '0;
        #1;
        chk("zero_id", 32'(rsp_id), 3);
        chk("zero_result", 32'(rsp_result), 0);
        chk("zero_flag", 32'(rsp_zero), 1);
        set_req(0, 4'd1, 4'd2, 3'd0);
        set_req(3, 4'd4, 4'd1, 3'd1);
        #1 chk("wrap_grant", 32'(req_ready), 32'b0001);
        cycle();
        // Asynchronous reset while a response is held.
        rsp_ready = 1'b0;
        req_valid = '0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(rsp_valid), 0);
        chk("async_rst_result", 32'(rsp_result), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        // Fairness: all requesters valid, one response per cycle in rotation.
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 4'(i + 3), 4'(i), 3'(i));
        for (int i = 0; i < 8; i++) begin
            #1 chk("rr_order", 32'(req_ready), 1 << (i % N));
            cycle();
        end
        req_valid = '0;
        cycle();
        // Randomized traffic against the model.
        repeat (400) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(2) == 0)
                    set_req(i, 4'($urandom), 4'($urandom), 3'($urandom));
                else if (req_valid[i] && $urandom_range(15) == 0)
                    req_valid[i] = 1'b0;
            end
            rsp_ready = $urandom_range(3) != 0;
            cycle();
            if (last_win >= 0) req_valid[last_win] = 1'b0;
        end
`ifdef ALU_RR_ARBITER_STATS_EN
        req_valid = '0;
        do_reset();
        rsp_ready = 1'b1;
        set_req(2, 4'd1, 4'd1, 3'd0);
        repeat (300) cycle();
        req_valid = '0;
        #1;
        chk("cnt2_sat", 32'(grant_cnt[23:16]), 255);
        chk("cnt0", 32'(grant_cnt[7:0]), 0);
        chk("cnt1", 32'(grant_cnt[15:8]), 0);
        chk("cnt3", 32'(grant_cnt[31:24]), 0);
        rst = 1'b1;
        #1 chk("cnt_clear", 32'(grant_cnt), 0);
        do_reset();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
